// File: rtl/mb_ctl_pkg.sv
// Shared types, MB input-mux codes and the slot-index decoder for the MB sequencer.
package mb_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_DLOAD  = 3'd2,
      ST_DWRITE = 3'd3,
      ST_STORE  = 3'd4
   } mb_state_e;

   localparam logic [2:0] MBIN_CACHE = 3'b000;
   localparam logic [2:0] MBIN_AR    = 3'b010;
   localparam logic [2:0] MBIN_MEM   = 3'b100;

   // 2-to-4 decode of a quad-word index into a slot bit (bit i = slot i)
   function automatic logic [3:0] onehot2(input logic [1:0] idx);
      logic [3:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mb_slot_scan.sv
// Lowest-set-bit finder over the 4-bit dirty-slot mask.
module mb_slot_scan
   import mb_ctl_pkg::*;
(
   input  logic [3:0] mask_i,
   output logic [1:0] idx_o,
   output logic       any_o
);

   // Priority encode from slot 0 upward
   always_comb begin
      idx_o = '0;
      if (mask_i[0])      idx_o = 2'd0;
      else if (mask_i[1]) idx_o = 2'd1;
      else if (mask_i[2]) idx_o = 2'd2;
      else if (mask_i[3]) idx_o = 2'd3;
      any_o = |mask_i;
   end

endmodule

// File: rtl/mb_ctl.sv
// MB sequencer: arbitrates fill / drain / store and steers MB slot loads and output select.
module mb_ctl
   import mb_ctl_pkg::*;
#(
   parameter int unsigned NSLOT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill_req,
   input  logic [1:0]       fill_first,
   input  logic             drain_req,
   input  logic [NSLOT-1:0] drain_mask,
   input  logic             store_req,
   input  logic [1:0]       store_word,
   output logic             fill_gnt,
   output logic             drain_gnt,
   output logic             store_gnt,
   input  logic             mem_valid,
   input  logic [1:0]       mem_word,
   input  logic             nxm,
   input  logic             cache_valid,
   input  logic [1:0]       cache_word,
   output logic             mem_wr_valid,
   input  logic             mem_wr_ack,
   output logic [NSLOT-1:0] mb_load,
   output logic [2:0]       mb_in_sel,
   output logic [1:0]       mb_sel,
   output logic             word_ready,
   output logic [NSLOT-1:0] slot_valid,
   output logic             fill_done,
   output logic             drain_done,
   output logic             store_done,
   output logic             fill_err,
   output logic             busy
);

   mb_state_e        state_q, state_d;
   logic [NSLOT-1:0] sv_q, sv_d, sv_next;
   logic [NSLOT-1:0] mask_q, mask_d;
   logic [1:0]       first_q, first_d;
   logic [1:0]       store_q, store_d;
   logic [1:0]       sel_q, sel_d;
   logic             wv_q, wv_d;
   logic             fill_gnt_q, fill_gnt_d, drain_gnt_q, drain_gnt_d, store_gnt_q, store_gnt_d;
   logic             wr_q, wr_d, fill_done_q, fill_done_d, drain_done_q, drain_done_d;
   logic             store_done_q, store_done_d, fill_err_q, fill_err_d;
   logic [NSLOT-1:0] load_vec;
   logic [2:0]       in_sel;
   logic [NSLOT-1:0] scan_in;
   logic [1:0]       scan_idx;
   logic             scan_any;

   // In DWRITE the scanner looks ahead at the mask with the current slot already retired,
   // so the next selection is ready on the edge that takes the ack.
   assign scan_in = (state_q == ST_DWRITE) ? (mask_q & ~onehot2(sel_q)) : mask_q;
   assign sv_next = sv_q | load_vec;

   mb_slot_scan u_scan (
      .mask_i (scan_in),
      .idx_o  (scan_idx),
      .any_o  (scan_any)
   );

   // State and registered-output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sv_q         <= '0;
         mask_q       <= '0;
         first_q      <= '0;
         store_q      <= '0;
         sel_q        <= '0;
         wv_q         <= 1'b0;
         fill_gnt_q   <= 1'b0;
         drain_gnt_q  <= 1'b0;
         store_gnt_q  <= 1'b0;
         wr_q         <= 1'b0;
         fill_done_q  <= 1'b0;
         drain_done_q <= 1'b0;
         store_done_q <= 1'b0;
         fill_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sv_q         <= sv_d;
         mask_q       <= mask_d;
         first_q      <= first_d;
         store_q      <= store_d;
         sel_q        <= sel_d;
         wv_q         <= wv_d;
         fill_gnt_q   <= fill_gnt_d;
         drain_gnt_q  <= drain_gnt_d;
         store_gnt_q  <= store_gnt_d;
         wr_q         <= wr_d;
         fill_done_q  <= fill_done_d;
         drain_done_q <= drain_done_d;
         store_done_q <= store_done_d;
         fill_err_q   <= fill_err_d;
      end
   end

   // Next-state: arbitration, slot bookkeeping and drain write sequencing
   always_comb begin
      state_d      = state_q;
      sv_d         = sv_q;
      mask_d       = mask_q;
      first_d      = first_q;
      store_d      = store_q;
      sel_d        = sel_q;
      wv_d         = wv_q;
      fill_gnt_d   = 1'b0;
      drain_gnt_d  = 1'b0;
      store_gnt_d  = 1'b0;
      wr_d         = 1'b0;
      fill_done_d  = 1'b0;
      drain_done_d = 1'b0;
      store_done_d = 1'b0;
      fill_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fill_req) begin
               state_d    = ST_FILL;
               fill_gnt_d = 1'b1;
               first_d    = fill_first;
               sv_d       = '0;
            end else if (drain_req) begin
               state_d     = ST_DLOAD;
               drain_gnt_d = 1'b1;
               mask_d      = drain_mask;
               sv_d        = '0;
            end else if (store_req) begin
               state_d     = ST_STORE;
               store_gnt_d = 1'b1;
               store_d     = store_word;
               sv_d        = '0;
            end
         end
         ST_FILL: begin
            if (nxm) begin
               fill_err_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (|load_vec) begin
               sv_d = sv_next;
               if (mem_word == first_q) wr_d = 1'b1;
               if (&sv_next) begin
                  fill_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_DLOAD: begin
            if (|load_vec) begin
               sv_d = sv_next;
               if (&sv_next) begin
                  if (scan_any) begin
                     state_d = ST_DWRITE;
                     wv_d    = 1'b1;
                     sel_d   = scan_idx;
                  end else begin
                     drain_done_d = 1'b1;
                     state_d      = ST_IDLE;
                  end
               end
            end
         end
         ST_DWRITE: begin
            if (mem_wr_ack) begin
               mask_d = scan_in;
               if (scan_any) begin
                  sel_d = scan_idx;
               end else begin
                  wv_d         = 1'b0;
                  drain_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         end
         ST_STORE: begin
            sv_d         = sv_next;
            store_done_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Mealy slot-load strobes and MB input mux select
   always_comb begin
      load_vec = '0;
      in_sel   = MBIN_CACHE;
      case (state_q)
         ST_FILL: begin
            if (mem_valid && !nxm && !sv_q[mem_word]) begin
               load_vec = onehot2(mem_word);
               in_sel   = MBIN_MEM;
            end
         end
         ST_DLOAD: begin
            if (cache_valid && !sv_q[cache_word]) begin
               load_vec = onehot2(cache_word);
               in_sel   = MBIN_CACHE;
            end
         end
         ST_STORE: begin
            load_vec = onehot2(store_q);
            in_sel   = MBIN_AR;
         end
         default: ;
      endcase
   end

   assign mb_load      = load_vec;
   assign mb_in_sel    = in_sel;
   assign mb_sel       = sel_q;
   assign mem_wr_valid = wv_q;
   assign slot_valid   = sv_q;
   assign fill_gnt     = fill_gnt_q;
   assign drain_gnt    = drain_gnt_q;
   assign store_gnt    = store_gnt_q;
   assign word_ready   = wr_q;
   assign fill_done    = fill_done_q;
   assign drain_done   = drain_done_q;
   assign store_done   = store_done_q;
   assign fill_err     = fill_err_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
